// File: rtl/rx_word_ctrl.sv
// Byte-to-word assembler: pops bytes from a FWFT byte FIFO and presents WORD_BYTES-wide words.
// Optional inter-byte timeout is compiled in with `define RX_WORD_TIMEOUT_EN.
module rx_word_ctrl #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_empty,
  input  logic [7:0]              rx_data,
  input  logic                    rx_error,
  output logic                    rx_pop,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    err_sticky,
  input  logic                    err_clear
);

  localparam int CNT_W = $clog2(WORD_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BYTES);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  if (WORD_BYTES < 1 || WORD_BYTES > 8 || TIMEOUT_CYCLES < 2 || CLK_FREQ < 1) begin : g_bad_param
    $error("rx_word_ctrl: illegal parameter value");
  end

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic                    err_q, err_d;
  logic                    fetch_pop;

`ifdef RX_WORD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = rx_error | (err_q & ~err_clear);
    fetch_pop  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!rx_empty) begin
          fetch_pop = 1'b1;
          for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_cnt_q == CNT_W'(i)) word_d[8*i +: 8] = rx_data;
          end
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: state_d = (byte_cnt_q == CNT_FULL) ? S_OUTPUT : S_FETCH;
      S_OUTPUT: begin
        if (word_ready) begin
          byte_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

`ifdef RX_WORD_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    if (fetch_pop) begin
      to_cnt_d = '0;
    end else if (state_q == S_FETCH && rx_empty &&
                 byte_cnt_q != '0 && byte_cnt_q < CNT_FULL) begin
      // Idle limit reached: drop the partial word and flag it
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        byte_cnt_d = '0;
        err_d      = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      byte_cnt_q <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      err_q      <= err_d;
    end
  end

`ifdef RX_WORD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  // Pop is combinational so the FIFO front byte is consumed in the cycle it is stored
  assign rx_pop     = fetch_pop & ~rst;
  assign word_data  = word_q;
  assign word_valid = (state_q == S_OUTPUT);
  assign err_sticky = err_q;

endmodule

// File: tb/tb_rx_word_ctrl.sv
// Scoreboard bench for rx_word_ctrl: FIFO model feeds bytes, a byte-grouping model predicts words.
module tb_rx_word_ctrl;
  localparam int WB = 4;
  localparam int TO = 20;
  localparam int WW = 8 * WB;

  logic          clk = 1'b0;
  logic          rst, rx_empty, rx_error, rx_pop, word_valid, word_ready, err_sticky, err_clear;
  logic [7:0]    rx_data;
  logic [WW-1:0] word_data;

  rx_word_ctrl #(.CLK_FREQ(12_000_000), .WORD_BYTES(WB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_error(rx_error),
    .rx_pop(rx_pop), .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .err_sticky(err_sticky), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]    fifo[$];
  logic [7:0]    partial[$];
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] got_words[$];

  bit ready_force = 1'b1;
  bit ready_val   = 1'b1;
  bit pop_sampled = 1'b0;
  bit prev_valid  = 1'b0;
  bit prev_pop    = 1'b0;
  logic [WW-1:0] prev_data = '0;
  int cyc = 0;
  int pops_total = 0;
  int last_pop_cyc = 0;
  int run_len = 0;
  int last_run = 0;

`ifdef RX_WORD_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void refresh_fifo();
    rx_empty = (fifo.size() == 0);
    rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endfunction

  // Reference model: consecutive bytes group into words, first byte in the low lane
  task automatic push_byte(input logic [7:0] b);
    logic [WW-1:0] w;
    fifo.push_back(b);
    partial.push_back(b);
    if (partial.size() == WB) begin
      w = '0;
      for (int i = 0; i < WB; i++) w[8*i +: 8] = partial[i];
      exp_q.push_back(w);
      partial.delete();
    end
    refresh_fifo();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || word_valid) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s: drain not reached after %0d cycles (fifo=%0d pending=%0d)",
               name, n, fifo.size(), exp_q.size());
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_fifo_empty(input string name, input int budget);
    int n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s: fifo still holds %0d bytes, required 0", name, fifo.size());
    end
  endtask

  // FIFO model: consumes the front byte on a clock edge where pop was high
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_sampled && fifo.size() != 0) fifo.delete(0);
    pop_sampled = 1'b0;
    refresh_fifo();
  end

  initial forever begin
    @(posedge clk);
    #1;
    word_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: protocol checks every cycle, scoreboard compare on each handshake
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      prev_valid = 1'b0; prev_pop = 1'b0; run_len = 0; pop_sampled = 1'b0;
    end else begin
      pop_sampled = rx_pop;
      check("pop_adjacent", 64'(rx_pop & prev_pop), 64'd0);
      check("pop_in_output", 64'(rx_pop & word_valid), 64'd0);
      if (rx_pop) begin
        pops_total++;
        last_pop_cyc = cyc;
      end
      if (word_valid) begin
        run_len++;
        if (!prev_valid) check("latency", 64'(cyc - last_pop_cyc), 64'd2);
        else             check("data_stable", 64'(word_data), 64'(prev_data));
        if (word_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got %0h expected no word", word_data);
          end else begin
            check("word_data", 64'(word_data), 64'(exp_q.pop_front()));
          end
          got_words.push_back(word_data);
          last_run = run_len;
          run_len  = 0;
        end
      end
      prev_valid = word_valid & ~word_ready;
      prev_data  = word_data;
      prev_pop   = rx_pop;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0;
    logic [7:0] b1, b2, b3;
    logic [WW-1:0] exp_w;
    bit err_exp;
    rst = 1'b1; rx_error = 1'b0; err_clear = 1'b0; word_ready = 1'b0;
    refresh_fifo();
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(word_valid), 64'd0);
    check("rst_data", 64'(word_data), 64'd0);
    check("rst_err", 64'(err_sticky), 64'd0);
    check("rst_pop", 64'(rx_pop), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic word with consumer always ready
    p0 = pops_total;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    drain("t1", 200);
    check("t1_pops", 64'(pops_total - p0), 64'd4);
    check("t1_valid_len", 64'(last_run), 64'd1);
    check("t1_word", 64'(got_words[$]), 64'h44332211);

    // Back-pressure: ready low for 10 valid cycles
    ready_val = 1'b0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'h55);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!word_valid && n < 100);
      check("t2_valid_seen", 64'(word_valid), 64'd1);
    end
    p0 = pops_total;
    repeat (9) @(negedge clk);
    #1;
    check("t2_no_pop", 64'(pops_total - p0), 64'd0);
    check("t2_fifo_held", 64'(fifo.size()), 64'd1);
    check("t2_front", 64'(rx_data), 64'h55);
    ready_val = 1'b1;
    @(negedge clk); #1;
    check("t2_valid_len", 64'(last_run), 64'd11);
    check("t2_word", 64'(got_words[$]), 64'h44332211);
    push_byte(8'h66); push_byte(8'h77); push_byte(8'h88);
    drain("t2", 200);
    check("t2_word2", 64'(got_words[$]), 64'h88776655);

    // Error set wins over simultaneous clear
    check("t3_err_idle", 64'(err_sticky), 64'd0);
    @(posedge clk); #1 rx_error = 1'b1; err_clear = 1'b1;
    @(posedge clk); #1;
    check("t3_err_set", 64'(err_sticky), 64'd1);
    rx_error = 1'b0;
    @(posedge clk); #1;
    check("t3_err_clr", 64'(err_sticky), 64'd0);
    err_clear = 1'b0;

    // Reset mid-word discards the partial bytes
    push_byte(8'hA1); push_byte(8'hB2);
    wait_fifo_empty("t4_pop", 50);
    rst = 1'b1;
    partial.delete();
    #1;
    check("t4_rst_valid", 64'(word_valid), 64'd0);
    check("t4_rst_data", 64'(word_data), 64'd0);
    check("t4_rst_pop", 64'(rx_pop), 64'd0);
    check("t4_rst_err", 64'(err_sticky), 64'd0);
    push_byte(8'hC3);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_pop_in_rst", 64'(rx_pop), 64'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    push_byte(b1); push_byte(b2); push_byte(b3);
    drain("t4", 200);
    check("t4_fresh_word", 64'(got_words[$]), 64'({b3, b2, b1, 8'hC3}));

    // Randomized traffic, random back-pressure and error pulses
    ready_force = 1'b0;
    err_exp = 1'b0;
    for (int i = 0; i < 80; i++) begin
      push_byte(8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if ($urandom_range(0, 15) == 0) begin
        rx_error = 1'b1; err_exp = 1'b1;
        @(posedge clk); #1 rx_error = 1'b0;
      end
    end
    while (partial.size() != 0) push_byte(8'($urandom));
    drain("t5", 2000);
    check("t5_err", 64'(err_sticky), 64'(err_exp));
    ready_force = 1'b1; ready_val = 1'b1;
    err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    check("t5_err_cleared", 64'(err_sticky), 64'd0);

    // Inter-byte idle gap: dropped with timeout, kept without
    push_byte(8'hAA); push_byte(8'hBB);
    wait_fifo_empty("t6_pop", 50);
    repeat (25) @(posedge clk);
    #2;
    check("t6_err", 64'(err_sticky), 64'(TIMEOUT_ON));
    if (TIMEOUT_ON) partial.delete();
    exp_w = TIMEOUT_ON ? WW'(32'h04030201) : WW'(32'h0201BBAA);
    w0 = got_words.size();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    drain("t6", 200);
    check("t6_words", 64'(got_words.size() > w0), 64'd1);
    if (got_words.size() > w0) check("t6_word", 64'(got_words[w0]), 64'(exp_w));
    while (partial.size() != 0) push_byte(8'($urandom));
    drain("t6_tail", 200);
    check("t6_err_final", 64'(err_sticky), 64'(TIMEOUT_ON));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
